// File: rtl/serial_adder_32.sv
// Bit-serial adder/subtractor: one full-adder stage, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port and enable subtraction.
module serial_adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] sumSh_q, sumSh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic subEff;
  logic faSum;
  logic faCout;

`ifdef SERIAL_ADDER_SUB_EN
  assign subEff = sub;
`else
  assign subEff = 1'b0;
`endif

  assign faSum  = aSh_q[0] ^ bSh_q[0] ^ carry_q;
  assign faCout = (aSh_q[0] & bSh_q[0]) | (carry_q & (aSh_q[0] ^ bSh_q[0]));

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sumSh_d = sumSh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = subEff ? ~b : b;
          carry_d = subEff;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sumSh_d = {faSum, sumSh_q[WIDTH-1:1]};
        aSh_d   = aSh_q >> 1;
        bSh_d   = bSh_q >> 1;
        carry_d = faCout;
        if (cnt_q == LAST) begin
          // Result registers are separate from the shift chain so they stay put through the next run.
          sum_d   = {faSum, sumSh_q[WIDTH-1:1]};
          cout_d  = faCout;
          ovf_d   = carry_q ^ faCout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sumSh_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sumSh_q <= sumSh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
